round_key_store: RTL and testbench



---
 rtl/round_key_store.sv | 159 +++++++++++++++
 tb/tb_round_key_store.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_store.sv
// Round-key store: captures the expanded AES schedule and replays it forward or reverse.
// Define ROUND_KEY_STORE_ZEROIZE_EN to add a zeroize input that wipes storage.
module round_key_store #(
  parameter int KEY_S = 128,
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_e,
  input  logic [IDX_W-1:0] round_no,
  input  logic [KEY_S-1:0] round_key,
  input  logic             en_i,
  input  logic             start,
  input  logic             decrypt,
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  input  logic             zeroize,
`endif
  output logic [KEY_S-1:0] key_o,
  output logic [IDX_W-1:0] key_idx_o,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             keys_loaded,
  output logic             busy,
  output logic             done_o,
  output logic             start_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e           state_q, state_d;
  logic [KEY_S-1:0] mem [0:NR];
  logic             dec_q;
  logic             zero_w;
  logic             wr_ok, clr;
  logic             start_ok, start_bad;
  logic             hs, last, abort;
  logic             step, finish;
  logic             valid_d, busy_d;
  logic             done_d, err_d;
  logic             ld;
  logic [IDX_W-1:0] idx_d;

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  assign zero_w = zeroize;
`else
  assign zero_w = 1'b0;
`endif

  assign wr_ok     = w_e && (round_no <= LAST);
  assign clr       = w_e && (round_no == '0);
  assign start_ok  = (state_q == IDLE) && start
                     && keys_loaded && !zero_w;
  assign start_bad = (state_q == IDLE) && start
                     && !keys_loaded && !zero_w;
  assign hs        = key_valid && key_ready;
  assign abort     = (state_q == STREAM) && (clr || zero_w);
  assign last      = dec_q ? (key_idx_o == '0)
                           : (key_idx_o == LAST);
  assign step      = (state_q == STREAM) && hs && !last && !abort;
  assign finish    = (state_q == STREAM) && hs && last && !abort;

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NR; i++) mem[i] <= '0;
    end else if (zero_w) begin
      for (int i = 0; i <= NR; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[round_no] <= round_key;
    end
  end
`else
  // Storage deliberately survives reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[round_no] <= round_key;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = STREAM;
      STREAM:  if (abort || finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = key_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    idx_d   = key_idx_o;
    ld      = 1'b0;
    unique case (1'b1)
      start_ok: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        idx_d   = decrypt ? LAST : '0;
        ld      = 1'b1;
      end
      step: begin
        idx_d = dec_q ? key_idx_o - 1'b1
                      : key_idx_o + 1'b1;
        ld    = 1'b1;
      end
      finish: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      abort: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      start_bad: err_d = 1'b1;
      default: ;
    endcase
  end

  // Registered read: a same-edge write is seen only on a later load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_o       <= '0;
      key_idx_o   <= '0;
      key_valid   <= 1'b0;
      busy        <= 1'b0;
      done_o      <= 1'b0;
      start_err   <= 1'b0;
      keys_loaded <= 1'b0;
      dec_q       <= 1'b0;
    end else begin
      key_valid <= valid_d;
      busy      <= busy_d;
      done_o    <= done_d;
      start_err <= err_d;
      if (zero_w) begin
        key_o     <= '0;
        key_idx_o <= '0;
      end else begin
        key_idx_o <= idx_d;
        if (ld) key_o <= mem[idx_d];
      end
      if (zero_w)    keys_loaded <= 1'b0;
      else if (en_i) keys_loaded <= 1'b1;
      else if (clr)  keys_loaded <= 1'b0;
      if (start_ok) dec_q <= decrypt;
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// Bench for round_key_store: directed steps with random data/backpressure
// checked against a queue-based model of the expected key stream.
module tb_round_key_store;

  localparam int NR = 10;

  logic         clk = 0;
  logic         reset;
  logic         w_e;
  logic [3:0]   round_no;
  logic [127:0] round_key;
  logic         en_i;
  logic         start;
  logic         decrypt;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  logic         zeroize;
`endif
  logic [127:0] key_o;
  logic [3:0]   key_idx_o;
  logic         key_valid;
  logic         key_ready;
  logic         keys_loaded;
  logic         busy;
  logic         done_o;
  logic         start_err;

  int vecs = 0;
  int errs = 0;

  logic [127:0] ref_mem [0:NR];
  bit           ref_loaded;
  logic [127:0] fips [0:NR] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  round_key_store #(.KEY_S(128), .NR(NR), .IDX_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .w_e         (w_e),
    .round_no    (round_no),
    .round_key   (round_key),
    .en_i        (en_i),
    .start       (start),
    .decrypt     (decrypt),
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    .zeroize     (zeroize),
`endif
    .key_o       (key_o),
    .key_idx_o   (key_idx_o),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .keys_loaded (keys_loaded),
    .busy        (busy),
    .done_o      (done_o),
    .start_err   (start_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wr(input int idx, input logic [127:0] k, input bit en);
    w_e = 1; round_no = idx[3:0]; round_key = k; en_i = en;
    if (idx <= NR) ref_mem[idx] = k;
    if (en) ref_loaded = 1;
    else if (idx == 0) ref_loaded = 0;
    @(negedge clk);
    w_e = 0; en_i = 0;
  endtask

  task automatic load(input bit use_fips);
    for (int i = 0; i <= NR; i++)
      wr(i, use_fips ? fips[i] : rnd128(), i == NR);
    chk("loaded", keys_loaded, ref_loaded);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_stream(input bit dec, input int mode);
    int q[$];
    int cyc;
    int budget;
    bit rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i <= NR; i++) q.push_back(dec ? NR - i : i);
    decrypt = dec; start = 1; key_ready = 0;
    @(negedge clk);
    start = 0; cyc = 0; budget = 200;
    while (q.size() > 0 && budget > 0) begin
      chk("valid", key_valid, 1);
      chk("busy", busy, 1);
      chk("idx", key_idx_o, q[0]);
      chk("key", key_o, ref_mem[q[0]]);
      chk("done_early", done_o, 0);
      chk("err_in_stream", start_err, 0);
      case (mode)
        0: rdy = 1;
        1: rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      key_ready = rdy;
      start = (mode == 1 && cyc == 2);
      decrypt = start ? ~dec : dec;
      if (rdy) void'(q.pop_front());
      cyc++; budget--;
      @(negedge clk);
    end
    start = 0; decrypt = dec; key_ready = 0;
    chk("timeout", budget > 0, 1);
    if (mode == 0) chk("cycles", cyc, NR + 1);
    chk("done", done_o, 1);
    chk("valid_end", key_valid, 0);
    chk("busy_end", busy, 0);
    @(negedge clk);
    chk("done_once", done_o, 0);
  endtask

  task automatic run_abort();
    int budget;
    decrypt = 0; start = 1; key_ready = 0;
    @(negedge clk);
    start = 0; budget = 50;
    while (key_idx_o != 4'd4 && budget > 0) begin
      chk("ab_key", key_o, ref_mem[key_idx_o]);
      key_ready = 1;
      budget--;
      @(negedge clk);
    end
    chk("ab_timeout", budget > 0, 1);
    chk("ab_valid_pre", key_valid, 1);
    key_ready = 1;
    wr(0, rnd128(), 0);
    key_ready = 0;
    chk("ab_valid", key_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_loaded", keys_loaded, 0);
    chk("ab_done", done_o, 0);
    @(negedge clk);
    chk("ab_done2", done_o, 0);
    for (int i = 1; i <= NR; i++) wr(i, rnd128(), i == NR);
    chk("ab_reload", keys_loaded, 1);
  endtask

  task automatic rejected_start();
    start = 1;
    @(negedge clk);
    start = 0;
    chk("err_pulse", start_err, 1);
    chk("err_valid", key_valid, 0);
    @(negedge clk);
    chk("err_one", start_err, 0);
    chk("err_valid2", key_valid, 0);
  endtask

  initial begin
    reset = 1; w_e = 0; round_no = 0; round_key = 0;
    en_i = 0; start = 0; decrypt = 0; key_ready = 0;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    zeroize = 0;
`endif
    ref_loaded = 0;
    for (int i = 0; i <= NR; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_key", key_o, 0);
    chk("rst_idx", key_idx_o, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_loaded", keys_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", start_err, 0);

    rejected_start();

    load(1);
    wr(0, fips[0], 1);
    chk("en_wins", keys_loaded, 1);
    wr(11 + int'($urandom_range(0, 4)), rnd128(), 0);
    chk("oob_loaded", keys_loaded, 1);

    run_stream(0, 0);
    run_stream(1, 0);
    run_stream(0, 1);
    run_stream(1, 2);

    for (int r = 0; r < 3; r++) begin
      load(0);
      run_stream(r[0], 2);
      run_stream(~r[0], 1);
    end

    run_abort();
    run_stream(1, 2);

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    decrypt = 0; start = 1; key_ready = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    zeroize = 1; key_ready = 1;
    @(negedge clk);
    zeroize = 0; key_ready = 0;
    for (int i = 0; i <= NR; i++) ref_mem[i] = '0;
    ref_loaded = 0;
    chk("zr_valid", key_valid, 0);
    chk("zr_loaded", keys_loaded, 0);
    chk("zr_key", key_o, 0);
    chk("zr_idx", key_idx_o, 0);
    chk("zr_done", done_o, 0);
    chk("zr_busy", busy, 0);
    rejected_start();
    load(0);
`endif

    decrypt = 0; start = 1; key_ready = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_valid", key_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_key", key_o, 0);
    chk("arst_idx", key_idx_o, 0);
    chk("arst_loaded", keys_loaded, 0);
    @(negedge clk);
    reset = 0; key_ready = 0;
    ref_loaded = 0;
    @(negedge clk);
    chk("arst_done", done_o, 0);
    rejected_start();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
